pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: ranks memory-wait, multi-cycle, load-use and branch hazards
// and turns the winning class into per-register stall/bubble controls.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = $clog2(MC_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              execute_i_need_jump,
  input  logic              fetch_wait,
  input  logic [REG_AW-1:0] decode_rs1,
  input  logic [REG_AW-1:0] decode_rs2,
  input  logic              decode_rs1_use,
  input  logic              decode_rs2_use,
  input  logic [REG_AW-1:0] execute_rd,
  input  logic              execute_rd_we,
  input  logic              execute_is_load,
  input  logic              execute_mc_start,
  input  logic              memory_wait,
  output logic              regF_stall,
  output logic              regD_stall,
  output logic              regE_stall,
  output logic              regM_stall,
  output logic              regW_stall,
  output logic              regD_bubble,
  output logic              regE_bubble,
  output logic              regM_bubble,
  output logic              regW_bubble,
  output logic              mc_busy,
  output logic              redirect_pending
);

  typedef enum logic {MC_IDLE, MC_BUSY} mc_state_e;

  localparam bit              MC_EN   = (MC_LAT > 1);
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             redirect_pending_q, redirect_pending_d;

  logic hz_mem, hz_mc, hz_lu, hz_br;
  logic mc_accept;
  logic rs1_hit, rs2_hit;

  always_comb begin
    rs1_hit   = decode_rs1_use && (decode_rs1 == execute_rd);
    rs2_hit   = decode_rs2_use && (decode_rs2 == execute_rd);
    mc_accept = MC_EN && (state_q == MC_IDLE) && execute_mc_start;
    hz_mem    = memory_wait;
    // The last BUSY cycle (count==1) is the cycle the op advances, so it is not a hazard.
    hz_mc     = mc_accept || ((state_q == MC_BUSY) && (count_q > CNT_ONE));
    hz_lu     = execute_is_load && execute_rd_we && (execute_rd != '0) && (rs1_hit || rs2_hit);
    hz_br     = execute_i_need_jump || redirect_pending_q;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      MC_IDLE: begin
        if (mc_accept && !hz_mem) begin
          state_d = MC_BUSY;
          count_d = MC_LOAD;
        end
      end
      MC_BUSY: begin
        // A memory stall freezes E, so the op makes no progress that cycle.
        if (!hz_mem) begin
          if (count_q > CNT_ONE) begin
            count_d = count_q - CNT_ONE;
          end else begin
            state_d = MC_IDLE;
            count_d = '0;
          end
        end
      end
      default: begin
        state_d = MC_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    if (redirect_pending_q) begin
      redirect_pending_d = fetch_wait;
    end else begin
      redirect_pending_d = execute_i_need_jump && fetch_wait && !hz_mem && !hz_mc && !hz_lu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= MC_IDLE;
      count_q            <= '0;
      redirect_pending_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      count_q            <= count_d;
      redirect_pending_q <= redirect_pending_d;
    end
  end

  always_comb begin
    regF_stall  = 1'b0;
    regD_stall  = 1'b0;
    regE_stall  = 1'b0;
    regM_stall  = 1'b0;
    regW_stall  = 1'b0;
    regD_bubble = 1'b0;
    regE_bubble = 1'b0;
    regM_bubble = 1'b0;
    regW_bubble = 1'b0;
    if (hz_mem) begin
      regF_stall  = 1'b1;
      regD_stall  = 1'b1;
      regE_stall  = 1'b1;
      regM_stall  = 1'b1;
      regW_bubble = 1'b1;
    end else if (hz_mc) begin
      regF_stall  = 1'b1;
      regD_stall  = 1'b1;
      regE_stall  = 1'b1;
      regM_bubble = 1'b1;
    end else if (hz_lu) begin
      regF_stall  = 1'b1;
      regD_stall  = 1'b1;
      regE_bubble = 1'b1;
    end else if (hz_br) begin
      // Only the branch itself kills E; a pending redirect just keeps D empty.
      regD_bubble = 1'b1;
      regE_bubble = execute_i_need_jump;
    end
  end

  assign mc_busy          = (state_q == MC_BUSY);
  assign redirect_pending = redirect_pending_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors with literal expectations plus a
// cycle-by-cycle comparison against a rule-level model of the hazard classes.
module tb_pipe_hazard_ctrl;
  localparam int AW  = 5;
  localparam int LAT = 4;

  // Output vector layout: stalls F,D,E,M,W | bubbles D,E,M,W | mc_busy | redirect_pending
  localparam logic [10:0] V_IDLE  = 11'b00000_0000_0_0;
  localparam logic [10:0] V_MEM   = 11'b11110_0001_0_0;
  localparam logic [10:0] V_MEMB  = 11'b11110_0001_1_0;
  localparam logic [10:0] V_MC    = 11'b11100_0010_0_0;
  localparam logic [10:0] V_MCB   = 11'b11100_0010_1_0;
  localparam logic [10:0] V_BUSY  = 11'b00000_0000_1_0;
  localparam logic [10:0] V_LU    = 11'b11000_0100_0_0;
  localparam logic [10:0] V_BR    = 11'b00000_1100_0_0;
  localparam logic [10:0] V_BRB   = 11'b00000_1100_1_0;
  localparam logic [10:0] V_PEND  = 11'b00000_1000_0_1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic jump, fwait, rs1_use, rs2_use, rd_we, is_load, mc_start, mwait;
  logic [AW-1:0] rs1, rs2, rd;
  logic f_s, d_s, e_s, m_s, w_s, d_b, e_b, m_b, w_b, busy, pend;
  logic [10:0] dut_v;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: whether a multi-cycle op occupies E, how many non-frozen cycles it has
  // spent there, and whether a redirect is still waiting for fetch.
  bit m_busy = 1'b0;
  bit m_pend = 1'b0;
  int m_done = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .MC_LAT(LAT)) u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .execute_i_need_jump (jump),
    .fetch_wait          (fwait),
    .decode_rs1          (rs1),
    .decode_rs2          (rs2),
    .decode_rs1_use      (rs1_use),
    .decode_rs2_use      (rs2_use),
    .execute_rd          (rd),
    .execute_rd_we       (rd_we),
    .execute_is_load     (is_load),
    .execute_mc_start    (mc_start),
    .memory_wait         (mwait),
    .regF_stall          (f_s),
    .regD_stall          (d_s),
    .regE_stall          (e_s),
    .regM_stall          (m_s),
    .regW_stall          (w_s),
    .regD_bubble         (d_b),
    .regE_bubble         (e_b),
    .regM_bubble         (m_b),
    .regW_bubble         (w_b),
    .mc_busy             (busy),
    .redirect_pending    (pend)
  );

  assign dut_v = {f_s, d_s, e_s, m_s, w_s, d_b, e_b, m_b, w_b, busy, pend};

  // Inputs only change 1 time unit after posedge, so the values seen here are the ones
  // the next edge will sample; the model is advanced to its post-edge state right away.
  always @(negedge clk) begin
    logic mem, start_ok, mc, lu, br;
    logic [10:0] exp;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_pend = 1'b0;
      m_done = 0;
    end else begin
      mem      = mwait;
      start_ok = !m_busy && mc_start && (LAT > 1);
      mc       = start_ok || (m_busy && (m_done + 1 < LAT));
      lu       = is_load && rd_we && (rd != 0) &&
                 ((rs1_use && rs1 == rd) || (rs2_use && rs2 == rd));
      br       = jump || m_pend;
      if (mem)      exp = V_MEM;
      else if (mc)  exp = V_MC;
      else if (lu)  exp = V_LU;
      else if (br)  exp = {5'b00000, 1'b1, jump, 2'b00, 2'b00};
      else          exp = V_IDLE;
      exp[1] = m_busy;
      exp[0] = m_pend;
      n_cmp++;
      if (dut_v !== exp) begin
        n_bad++;
        $display("FAIL model t=%0t: got %b expected %b", $time, dut_v, exp);
      end
      if (!mem) begin
        if (start_ok) begin
          m_busy = 1'b1;
          m_done = 1;
        end else if (m_busy) begin
          if (m_done + 1 >= LAT) begin
            m_busy = 1'b0;
            m_done = 0;
          end else begin
            m_done++;
          end
        end
      end
      if (m_pend) m_pend = fwait;
      else        m_pend = jump && fwait && !mem && !mc && !lu;
    end
  end

  task automatic idle();
    jump = 0; fwait = 0; rs1_use = 0; rs2_use = 0; rd_we = 0;
    is_load = 0; mc_start = 0; mwait = 0;
    rs1 = '0; rs2 = '0; rd = '0;
  endtask

  task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end else begin
      $display("vec %-16s outputs=%b", name, got);
    end
  endtask

  // One clock of the current inputs, checked against a hand-computed vector.
  task automatic cyc(input string name, input logic [10:0] exp);
    @(negedge clk);
    chk(name, dut_v, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input logic [AW-1:0] r, input logic [AW-1:0] s1, input logic u1,
                          input logic [AW-1:0] s2, input logic u2);
    idle();
    is_load = 1; rd_we = 1; rd = r;
    rs1 = s1; rs1_use = u1; rs2 = s2; rs2_use = u2;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("in_reset", V_IDLE);
    rst_n = 1'b1;
    cyc("post_reset", V_IDLE);

    // Load-use
    load_use(5'd5, 5'd5, 1, 5'd0, 0);  cyc("lu_rs1", V_LU);
    idle();                            cyc("lu_release", V_IDLE);
    load_use(5'd0, 5'd0, 1, 5'd0, 1);  cyc("lu_rd0", V_IDLE);
    load_use(5'd7, 5'd3, 1, 5'd7, 1);  cyc("lu_rs2", V_LU);
    load_use(5'd7, 5'd3, 1, 5'd7, 0);  cyc("lu_rs2_unused", V_IDLE);
    load_use(5'd9, 5'd9, 1, 5'd0, 0);
    is_load = 0;                       cyc("alu_no_lu", V_IDLE);

    // Multi-cycle op, plain
    idle(); mc_start = 1; cyc("mc_c0", V_MC);
    idle();               cyc("mc_c1", V_MCB);
    cyc("mc_c2", V_MCB);
    cyc("mc_c3_release", V_BUSY);
    cyc("mc_done", V_IDLE);

    // Multi-cycle op frozen by memory wait at count 2; start while busy ignored
    idle(); mc_start = 1; cyc("mcm_c0", V_MC);
    idle(); mc_start = 1; cyc("mcm_c1_restart", V_MCB);
    idle(); mwait = 1;    cyc("mcm_c2_mem", V_MEMB);
    cyc("mcm_c3_mem", V_MEMB);
    idle();               cyc("mcm_c4", V_MCB);
    mc_start = 1;         cyc("mcm_c5_release", V_BUSY);
    idle();               cyc("mcm_done", V_IDLE);

    // Branch with fetch_wait for 3 cycles
    idle(); jump = 1; fwait = 1; cyc("br_c0", V_BR);
    idle(); fwait = 1;           cyc("br_c1_pend", V_PEND);
    cyc("br_c2_pend", V_PEND);
    idle();                      cyc("br_c3_pend", V_PEND);
    cyc("br_done", V_IDLE);

    // Branch with fetch ready
    idle(); jump = 1; cyc("br_nowait", V_BR);
    idle();           cyc("br_nowait_done", V_IDLE);

    // Branch with load-use: LU wins, nothing pending afterwards
    load_use(5'd4, 5'd4, 1, 5'd0, 0); jump = 1; fwait = 1; cyc("br_lu", V_LU);
    idle(); cyc("br_lu_after", V_IDLE);

    // Branch deferred by memory wait
    idle(); jump = 1; fwait = 1; mwait = 1; cyc("br_mem_c0", V_MEM);
    cyc("br_mem_c1", V_MEM);
    idle(); jump = 1;            cyc("br_mem_c2", V_BR);
    idle();                      cyc("br_mem_done", V_IDLE);

    // Branch deferred by multi-cycle op, then redirect pending
    idle(); mc_start = 1; jump = 1; fwait = 1; cyc("br_mc_c0", V_MC);
    mc_start = 0;                              cyc("br_mc_c1", V_MCB);
    cyc("br_mc_c2", V_MCB);
    cyc("br_mc_c3", V_BRB);
    idle(); fwait = 1; cyc("br_mc_c4", V_PEND);
    idle();            cyc("br_mc_c5", V_PEND);
    cyc("br_mc_done", V_IDLE);

    // Reset mid-busy at count 2, then a fresh op gets the full stall
    idle(); mc_start = 1; cyc("rst_mc_c0", V_MC);
    idle();               cyc("rst_mc_c1", V_MCB);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", dut_v, V_IDLE);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("rst_release", V_IDLE);
    mc_start = 1; cyc("rst_new_c0", V_MC);
    idle();       cyc("rst_new_c1", V_MCB);
    cyc("rst_new_c2", V_MCB);
    cyc("rst_new_c3", V_BUSY);
    cyc("rst_new_done", V_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
